// File: rtl/dcache_responder.sv
// dcache_responder: word-addressed data RAM answering one CPU request at a time after LATENCY wait cycles
module dcache_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic        dcache_en,
  input  logic        dcache_wr,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rdy,
  output logic        dcache_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q;
  logic wr_q;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] index;
  logic valid, access;
  assign index = addr_q[ADDR_WIDTH+1:2];
  assign valid = (addr_q[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]) && (addr_q[1:0] == 2'b00);
  assign access = (state == BUSY) && (cnt == 4'd0);
  always_comb begin
    next = IDLE;
    next = state == IDLE ? (dcache_en ? BUSY : IDLE) :
           state == BUSY ? (access ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clock)
    if (reset) begin
      cnt          <= 4'd0;
      dcache_rdy   <= 1'b0;
      dcache_err   <= 1'b0;
      dcache_rdata <= 32'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wr_q         <= 1'b0;
    end else begin
      dcache_rdy   <= access;
      dcache_err   <= access && !valid;
      dcache_rdata <= (access && valid && !wr_q) ? mem[index] : 32'd0;
      if (state == IDLE && dcache_en) begin
        addr_q  <= dcache_addr;
        wdata_q <= dcache_wdata;
        wr_q    <= dcache_wr;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == BUSY) cnt <= cnt - 4'd1;
    end
  // reset on the access edge suppresses the write
  always_ff @(posedge clock)
    if (!reset && access && valid && wr_q) mem[index] <= wdata_q;
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed requests with a response scoreboard per DUT (LATENCY 2 and LATENCY 4)
module tb_dcache_responder;
  logic clock = 0, reset = 1, reset4 = 1;
  logic [31:0] addr = 0, wdata = 0;
  logic en = 0, en4 = 0, wr = 0;
  logic [31:0] rdata, rdata4;
  logic rdy, err, rdy4, err4;
  logic [32:0] q[$], q4[$];
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  dcache_responder #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clock(clock), .reset(reset), .dcache_addr(addr), .dcache_wdata(wdata),
    .dcache_en(en), .dcache_wr(wr), .dcache_rdata(rdata), .dcache_rdy(rdy), .dcache_err(err));

  dcache_responder #(.ADDR_WIDTH(10), .LATENCY(4), .BASE_ADDR(32'h0)) dut4 (
    .clock(clock), .reset(reset4), .dcache_addr(addr), .dcache_wdata(wdata),
    .dcache_en(en4), .dcache_wr(wr), .dcache_rdata(rdata4), .dcache_rdy(rdy4), .dcache_err(err4));

  always @(negedge clock) begin
    logic [32:0] e;
    if (rdy) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL rdy_unexpected: got rdy with err=%0b rdata=%h, no request pending", err, rdata);
      end else begin
        e = q.pop_front();
        if ({err, rdata} !== e) begin
          fails++;
          $display("FAIL resp: got err=%0b rdata=%h, expected err=%0b rdata=%h", err, rdata, e[32], e[31:0]);
        end
      end
    end else if (!reset) begin
      tests++;
      if (err !== 1'b0 || rdata !== 32'd0) begin
        fails++;
        $display("FAIL idle_outputs: got err=%0b rdata=%h, expected 0 outside rdy", err, rdata);
      end
    end
    if (rdy4) begin
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL rdy4_unexpected: got rdy with err=%0b rdata=%h, no request pending", err4, rdata4);
      end else begin
        e = q4.pop_front();
        if ({err4, rdata4} !== e) begin
          fails++;
          $display("FAIL resp4: got err=%0b rdata=%h, expected err=%0b rdata=%h", err4, rdata4, e[32], e[31:0]);
        end
      end
    end else if (!reset4) begin
      tests++;
      if (err4 !== 1'b0 || rdata4 !== 32'd0) begin
        fails++;
        $display("FAIL idle_outputs4: got err=%0b rdata=%h, expected 0 outside rdy", err4, rdata4);
      end
    end
  end

  task automatic req(input bit d4, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input bit ee, input bit hold);
    int n;
    bit got;
    @(negedge clock);
    addr = a; wdata = wd; wr = w;
    if (d4) begin en4 = 1; q4.push_back({ee, er}); end
    else begin en = 1; q.push_back({ee, er}); end
    n = 0; got = 0;
    while (!got && n < 50) begin
      @(negedge clock);
      n++;
      got = d4 ? rdy4 : rdy;
    end
    tests++;
    if (!got || n != (d4 ? 5 : 3)) begin
      fails++;
      $display("FAIL latency addr=%h: got rdy=%0b after %0d cycles, expected %0d", a, got, n, d4 ? 5 : 3);
    end
    if (hold) @(negedge clock);
    en = 0; en4 = 0;
    repeat (8) @(negedge clock);
  endtask

  task automatic chk_zero(input string name, input logic r, input logic e, input logic [31:0] d);
    tests++;
    if (r !== 1'b0 || e !== 1'b0 || d !== 32'd0) begin
      fails++;
      $display("FAIL %s: got rdy=%0b err=%0b rdata=%h, expected all 0", name, r, e, d);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 0; reset4 = 0;
    chk_zero("reset_state", rdy, err, rdata);
    chk_zero("reset_state4", rdy4, err4, rdata4);
    req(0, 1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0);
    req(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0);
    req(0, 1, 32'h20, 32'h1, 32'h0, 0, 1);
    req(0, 1, 32'h24, 32'h2, 32'h0, 0, 1);
    req(0, 0, 32'h20, 32'h0, 32'h1, 0, 1);
    req(0, 0, 32'h24, 32'h0, 32'h2, 0, 1);
    req(0, 1, 32'h13, 32'h1234_5678, 32'h0, 1, 0);
    req(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0);
    req(0, 0, 32'h1000, 32'h0, 32'h0, 1, 0);
    req(0, 1, 32'h1010, 32'h5555_5555, 32'h0, 1, 0);
    req(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0);
    req(0, 1, 32'hFFC, 32'hA5A5_A5A5, 32'h0, 0, 0);
    req(0, 0, 32'hFFC, 32'h0, 32'hA5A5_A5A5, 0, 0);
    req(0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    // store aborted by reset two cycles into BUSY
    @(negedge clock);
    addr = 32'h40; wdata = 32'h7; wr = 1; en4 = 1;
    repeat (2) @(negedge clock);
    reset4 = 1; en4 = 0;
    @(negedge clock);
    chk_zero("after_reset_edge", rdy4, err4, rdata4);
    reset4 = 0;
    repeat (10) @(negedge clock);
    req(1, 0, 32'h40, 32'h0, 32'h0, 0, 0);
    // reset landing exactly on the access edge
    @(negedge clock);
    addr = 32'h44; wdata = 32'h9; wr = 1; en4 = 1;
    repeat (4) @(negedge clock);
    reset4 = 1; en4 = 0;
    @(negedge clock);
    chk_zero("after_access_reset", rdy4, err4, rdata4);
    reset4 = 0;
    repeat (10) @(negedge clock);
    req(1, 0, 32'h44, 32'h0, 32'h0, 0, 0);
    req(1, 1, 32'h48, 32'h3, 32'h0, 0, 1);
    req(1, 0, 32'h48, 32'h0, 32'h3, 0, 0);
    tests++;
    if (q.size() != 0 || q4.size() != 0) begin
      fails++;
      $display("FAIL pending: got %0d/%0d unanswered requests, expected 0/0", q.size(), q4.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
